// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: ALU op classes, widths
// and the control bundle carried between decode and the pipeline registers.
package mips_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Purely combinational.
module load_use_detect #(
    parameter int ADDR_W = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    output logic              load_use
);

    logic rs_hit;
    logic rt_hit;
    logic ex_is_load;

    // A load into $zero produces nothing to wait for.
    assign ex_is_load = ex_valid & ex_mem_read & (ex_rt != ADDR_W'(mips_pkg::REG_ZERO));
    assign rs_hit     = id_uses_rs & (id_rs == ex_rt);
    assign rt_hit     = id_uses_rt & (id_rt == ex_rt);
    assign load_use   = ex_is_load & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion and saturating
// bubble/flush counters for performance debug.
module id_ex_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ID_valid,
    input  logic                      ID_flush,
    input  logic                      ID_reg_write,
    input  logic                      ID_mem_to_reg,
    input  logic                      ID_mem_read,
    input  logic                      ID_mem_write,
    input  logic                      ID_branch,
    input  logic                      ID_alu_src,
    input  logic                      ID_reg_dst,
    input  logic                      ID_uses_rs,
    input  logic                      ID_uses_rt,
    input  logic [1:0]                ID_alu_op,
    input  logic [DATA_WIDTH-1:0]     ID_pc_plus4,
    input  logic [DATA_WIDTH-1:0]     ID_read_data1,
    input  logic [DATA_WIDTH-1:0]     ID_read_data2,
    input  logic [DATA_WIDTH-1:0]     ID_sign_ext_imm,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rs,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rt,
    input  logic [REG_ADDR_WIDTH-1:0] ID_rd,
    output logic                      ID_hazard_stall,
    output logic                      EX_valid,
    output logic                      EX_reg_write,
    output logic                      EX_mem_to_reg,
    output logic                      EX_mem_read,
    output logic                      EX_mem_write,
    output logic                      EX_branch,
    output logic                      EX_alu_src,
    output logic                      EX_reg_dst,
    output logic [1:0]                EX_alu_op,
    output logic [5:0]                EX_funct,
    output logic [DATA_WIDTH-1:0]     EX_pc_plus4,
    output logic [DATA_WIDTH-1:0]     EX_read_data1,
    output logic [DATA_WIDTH-1:0]     EX_read_data2,
    output logic [DATA_WIDTH-1:0]     EX_sign_ext_imm,
    output logic [REG_ADDR_WIDTH-1:0] EX_rs,
    output logic [REG_ADDR_WIDTH-1:0] EX_rt,
    output logic [REG_ADDR_WIDTH-1:0] EX_rd,
    output logic [CNT_WIDTH-1:0]      stall_count,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    mips_pkg::ctrl_t id_ctrl;
    mips_pkg::ctrl_t ctrl_d, ctrl_q;
    logic            valid_d, valid_q;

    logic [DATA_WIDTH-1:0]     pc_d, pc_q;
    logic [DATA_WIDTH-1:0]     rd1_d, rd1_q;
    logic [DATA_WIDTH-1:0]     rd2_d, rd2_q;
    logic [DATA_WIDTH-1:0]     imm_d, imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs_d, rs_q;
    logic [REG_ADDR_WIDTH-1:0] rt_d, rt_q;
    logic [REG_ADDR_WIDTH-1:0] rd_d, rd_q;

    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_q;

    logic load_use;
    logic bubble;

    assign id_ctrl = '{
        reg_write:  ID_reg_write,
        mem_to_reg: ID_mem_to_reg,
        mem_read:   ID_mem_read,
        mem_write:  ID_mem_write,
        branch:     ID_branch,
        alu_src:    ID_alu_src,
        reg_dst:    ID_reg_dst,
        alu_op:     ID_alu_op
    };

    load_use_detect #(
        .ADDR_W (REG_ADDR_WIDTH)
    ) u_load_use (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_uses_rs  (ID_uses_rs),
        .id_uses_rt  (ID_uses_rt),
        .id_rs       (ID_rs),
        .id_rt       (ID_rt),
        .load_use    (load_use)
    );

    // A flush already kills the ID instruction, so it must not also freeze fetch.
    assign ID_hazard_stall = load_use & ID_valid & ~ID_flush;
    assign bubble          = ID_flush | ID_hazard_stall;

    always_comb begin
        valid_d = 1'b0;
        ctrl_d  = mips_pkg::CTRL_BUBBLE;
        pc_d    = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        if (!bubble) begin
            valid_d = ID_valid;
            // Invalid slots keep their fields but must never write state.
            ctrl_d  = ID_valid ? id_ctrl : mips_pkg::CTRL_BUBBLE;
            pc_d    = ID_pc_plus4;
            rd1_d   = ID_read_data1;
            rd2_d   = ID_read_data2;
            imm_d   = ID_sign_ext_imm;
            rs_d    = ID_rs;
            rt_d    = ID_rt;
            rd_d    = ID_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= mips_pkg::CTRL_BUBBLE;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    // ID_hazard_stall is already masked by flush, so the two never count together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (ID_flush && ID_valid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
            if (ID_hazard_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign EX_valid        = valid_q;
    assign EX_reg_write    = ctrl_q.reg_write;
    assign EX_mem_to_reg   = ctrl_q.mem_to_reg;
    assign EX_mem_read     = ctrl_q.mem_read;
    assign EX_mem_write    = ctrl_q.mem_write;
    assign EX_branch       = ctrl_q.branch;
    assign EX_alu_src      = ctrl_q.alu_src;
    assign EX_reg_dst      = ctrl_q.reg_dst;
    assign EX_alu_op       = ctrl_q.alu_op;
    assign EX_funct        = imm_q[5:0];
    assign EX_pc_plus4     = pc_q;
    assign EX_read_data1   = rd1_q;
    assign EX_read_data2   = rd2_q;
    assign EX_sign_ext_imm = imm_q;
    assign EX_rs           = rs_q;
    assign EX_rt           = rt_q;
    assign EX_rd           = rd_q;
    assign stall_count     = stall_cnt_q;
    assign flush_count     = flush_cnt_q;

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures decoded control and operands from ID each cycle and drives the EX stage, including EX_alu_op and EX_funct into the ALU-select decode.
- Contains load-use hazard detection: it stalls PC and IF/ID, and inserts a bubble into EX.
- Keeps saturating bubble and flush counters for performance debug.

Parameters:
- DATA_WIDTH, 32, width of operand, PC and immediate fields
- REG_ADDR_WIDTH, 5, register specifier width
- CNT_WIDTH, 16, width of each performance counter

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- ID_valid  input  1  ID holds a real instruction
- ID_flush  input  1  branch/jump redirect; kill the instruction entering EX
- ID_reg_write, ID_mem_to_reg, ID_mem_read, ID_mem_write, ID_branch, ID_alu_src, ID_reg_dst  input  1 each  decoded control
- ID_uses_rs, ID_uses_rt  input  1 each  source-register usage flags
- ID_alu_op  input  2  ALU op class
- ID_pc_plus4, ID_read_data1, ID_read_data2, ID_sign_ext_imm  input  DATA_WIDTH each  operands
- ID_rs, ID_rt, ID_rd  input  REG_ADDR_WIDTH each  register specifiers
- ID_hazard_stall  output  1  combinational; freeze PC and IF/ID this cycle
- EX_valid  output  1  EX holds a real instruction
- EX_reg_write, EX_mem_to_reg, EX_mem_read, EX_mem_write, EX_branch, EX_alu_src, EX_reg_dst  output  1 each  registered control
- EX_alu_op  output  2  registered ALU op class
- EX_funct  output  6  registered ID_sign_ext_imm[5:0]
- EX_pc_plus4, EX_read_data1, EX_read_data2, EX_sign_ext_imm  output  DATA_WIDTH each  registered operands
- EX_rs, EX_rt, EX_rd  output  REG_ADDR_WIDTH each  registered specifiers
- stall_count, flush_count  output  CNT_WIDTH each  performance counters

Behaviour:
- Reset (async, high): every registered output is 0, including EX_valid, EX_alu_op=2'b00, EX_funct=0 and both counters. ID_hazard_stall is 0 while EX_valid=0.
- load_use (combinational) = EX_valid & EX_mem_read & (EX_rt != 0) & ((ID_uses_rs & ID_rs==EX_rt) | (ID_uses_rt & ID_rt==EX_rt)).
- ID_hazard_stall = load_use & ID_valid & ~ID_flush.
- Latency: 1 cycle ID to EX. No internal hold path; the register updates every clock edge.
- Per-edge priority, highest first:
  - flush: ID_flush=1 loads a bubble. flush_count increments if ID_valid=1.
  - stall: ID_hazard_stall=1 loads a bubble. stall_count increments.
  - load: otherwise, all ID fields are captured. EX_valid = ID_valid.
- Bubble: all EX control bits 0, EX_valid 0, EX_alu_op 2'b00, all datapath and specifier fields 0. A bubble therefore never writes the register file or memory.
- When ID_valid=0 and no flush/stall, fields are still captured but EX_valid=0. In that case the control bits must be forced to 0, so an invalid slot behaves as a bubble.
- Load-use stall lasts exactly one cycle. After the bubble, EX_valid=0, so load_use drops and the held ID instruction advances on the next edge.
- Back-to-back loads each produce at most one stall. A dependent chain produces one stall per load.
- Register $zero: EX_rt==0 never stalls.
- Counters saturate at all-ones and do not wrap. Flush and stall cannot both count in one cycle.
- Reset mid-stall: outputs clear immediately. No pending stall survives reset.

Decomposition:
- Shared package (mips_pkg): ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_FUNCT=2'b10, DATA_WIDTH, REG_ADDR_WIDTH, REG_ZERO=5'd0. Also a packed control-bundle typedef (reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op) shared with the decoder and EX/MEM register.
- One natural sub-module: load_use_detect (purely combinational comparator producing load_use). The saturating counter stays inline.

Test Plan:
- Reset asserted mid-run with EX_valid=1 and EX_alu_op=2'b10 -> all outputs 0 asynchronously, before the next edge; counters 0.
- Plain load: ID_valid=1, ID_alu_op=2'b10, ID_sign_ext_imm=32'h0000_0022, ID_reg_write=1 -> next cycle EX_alu_op=2'b10, EX_funct=6'h22, EX_reg_write=1, EX_valid=1.
- Load-use: EX holds lw (EX_mem_read=1, EX_rt=8); ID add with ID_rs=8, ID_uses_rs=1 -> ID_hazard_stall=1 for one cycle. Next cycle EX is a bubble (EX_valid=0, all control 0) and stall_count=1. The add enters EX on the following edge.
- Zero register: EX lw with EX_rt=0, ID_rs=0 -> ID_hazard_stall=0, no bubble.
- Flush overrides stall: load-use condition plus ID_flush=1 -> ID_hazard_stall=0, bubble inserted, flush_count+1, stall_count unchanged.
- Saturation: preload the stall path to force 65535 stalls, then one more -> stall_count stays 16'hFFFF.
